pll_lock_ctrl: RTL and testbench
================================

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 SHALL have parameter F_DEFAULT, 32'h9C40, start frequency word (40 kHz) loaded after reset.
REQ-002 SHALL have parameter LOAD_CYC, 4, cycles load_freq stays high in LOAD.
REQ-003 SHALL have parameter LOCK_CNT, 256, consecutive in-window cycles needed to declare lock.
REQ-004 SHALL have parameter LOSS_CNT, 16, consecutive out-of-window cycles needed to declare lock loss.
REQ-005 SHALL have parameter ACQ_TIMEOUT, 65535, maximum ACQUIRE cycles per attempt.
REQ-006 SHALL have parameter MAX_RETRY, 3, acquisition attempts before FAULT.
REQ-007 SHALL have parameters LG_ACQ, 5'd8, and LG_TRK, 5'd16: loop-gain shift for acquisition and tracking.
REQ-008 clk  input  1  system clock; all state changes on its rising edge.
REQ-009 nrst  input  1  reset, synchronous, active-high.
REQ-010 swipt_alive  input  1  heartbeat-derived SWIPT link-alive flag.
REQ-011 pll_error  input  2  PLL error; bit1 = phase error outside window, bit0 = phase-detector sign.
REQ-012 cfg_wr  input  1  single-cycle strobe that writes cfg_freq.
REQ-013 cfg_freq  input  32  new start frequency word.
REQ-014 fault_clr  input  1  single-cycle strobe that clears FAULT.
REQ-015 load_freq  output  1  forces the PLL to load freq_out.
REQ-016 freq_out  output  32  frequency word presented to the PLL.
REQ-017 lgcoef  output  5  PLL loop-gain coefficient.
REQ-018 pll_in_sel  output  1  0 = PLL input from ADC comparator, 1 = loopback of pll_error[0].
REQ-019 locked  output  1  PLL is locked (TRACK state).
REQ-020 fault  output  1  retries exhausted; sticky.
REQ-021 state  output  3  IDLE=0, LOAD=1, ACQUIRE=2, TRACK=3, FAULT=4.

Function
REQ-022 All outputs SHALL be registered.
REQ-023 IDLE: load_freq=1, pll_in_sel=0, locked=0, retry count=0; if swipt_alive=1, go to LOAD the next cycle.
REQ-024 cfg_wr SHALL update freq_out the next cycle only in IDLE or FAULT; in any other state it is ignored, with no queuing.
REQ-025 LOAD: load_freq=1 for exactly LOAD_CYC cycles, then go to ACQUIRE with load_freq=0 and pll_in_sel=1.
REQ-026 ACQUIRE: lgcoef=LG_ACQ. An in-window counter increments when pll_error[1]=0 and clears when pll_error[1]=1.
REQ-027 When the in-window counter reaches LOCK_CNT, the next state SHALL be TRACK, with locked=1 and lgcoef=LG_TRK in the same cycle.
REQ-028 An ACQUIRE cycle counter reaching ACQ_TIMEOUT SHALL increment the retry count and go to LOAD if retries<MAX_RETRY, otherwise to FAULT.
REQ-029 If lock and timeout occur in the same cycle, lock SHALL win.
REQ-030 TRACK: a loss counter increments when pll_error[1]=1 and clears when pll_error[1]=0.
REQ-031 When the loss counter reaches LOSS_CNT, the next state SHALL be ACQUIRE with locked=0, lgcoef=LG_ACQ and all counters cleared; the retry count is not incremented.
REQ-032 FAULT: fault=1, load_freq=1, pll_in_sel=0, locked=0.
REQ-033 In FAULT, only fault_clr (to IDLE, fault=0) or reset SHALL exit the state; swipt_alive is ignored.
REQ-034 swipt_alive=0 in LOAD, ACQUIRE or TRACK SHALL force IDLE the next cycle, with load_freq=1, locked=0 and counters cleared; freq_out is held.
REQ-035 Priority SHALL be reset > swipt_alive loss > fault_clr > lock > timeout > loss.
REQ-036 Counters SHALL saturate and never wrap: 16-bit for timeout, 9-bit for lock, 5-bit for loss, 2-bit for retry.

Reset
REQ-037 While nrst=1 at a clock edge, the block SHALL enter state=IDLE, load_freq=1, freq_out=F_DEFAULT, lgcoef=LG_ACQ, pll_in_sel=0, locked=0, fault=0, with all counters 0.
REQ-038 Reset asserted mid-operation SHALL abort any state within one cycle.
REQ-039 Reset SHALL override cfg_wr and fault_clr in the same cycle.

Verification
REQ-040 Reset, then swipt_alive=1 with pll_error=2'b00 held -> LOAD for 4 cycles, then ACQUIRE; locked=1 and lgcoef=16 exactly 256 cycles after ACQUIRE entry.
REQ-041 In ACQUIRE, pll_error[1]=1 for 1 cycle at in-window count 200 -> count restarts; lock asserts 256 cycles after the glitch.
REQ-042 In TRACK, pll_error[1]=1 for 15 cycles -> stays locked; for 16 cycles -> ACQUIRE, locked=0, lgcoef=8.
REQ-043 pll_error[1]=1 held -> three timeouts of 65535 cycles each, then state=4 and fault=1; fault_clr -> IDLE, fault=0.
REQ-044 cfg_wr with 32'h1388 in IDLE -> freq_out=32'h1388; cfg_wr in TRACK -> freq_out unchanged.
REQ-045 swipt_alive dropped in TRACK -> IDLE next cycle with load_freq=1 and locked=0; nrst=1 in ACQUIRE -> all reset values next cycle.

Source files
------------

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL start-up, acquisition/tracking sequencer with retry and sticky fault.
// Outputs are registered from the next-state decode so they change together with state.
module pll_lock_ctrl #(
    parameter logic [31:0] F_DEFAULT   = 32'h9C40,
    parameter int unsigned LOAD_CYC    = 4,
    parameter int unsigned LOCK_CNT    = 256,
    parameter int unsigned LOSS_CNT    = 16,
    parameter int unsigned ACQ_TIMEOUT = 65535,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [4:0]  LG_ACQ      = 5'd8,
    parameter logic [4:0]  LG_TRK      = 5'd16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        swipt_alive_i,
    input  logic [1:0]  pll_error_i,
    input  logic        cfg_wr_i,
    input  logic [31:0] cfg_freq_i,
    input  logic        fault_clr_i,
    output logic        load_freq_o,
    output logic [31:0] freq_out_o,
    output logic [4:0]  lgcoef_o,
    output logic        pll_in_sel_o,
    output logic        locked_o,
    output logic        fault_o,
    output logic [2:0]  state_o
);
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, ACQUIRE = 3'd2, TRACK = 3'd3, FAULT = 3'd4} state_t;

    localparam logic [7:0]  LD_LAST = 8'(LOAD_CYC - 1);
    localparam logic [8:0]  LOCK_C  = 9'(LOCK_CNT);
    localparam logic [4:0]  LOSS_C  = 5'(LOSS_CNT);
    localparam logic [15:0] TMO_C   = 16'(ACQ_TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] freq_q, freq_d;
    logic [7:0]  ld_q, ld_d;
    logic [15:0] acq_q, acq_d;
    logic [8:0]  win_q, win_d;
    logic [4:0]  loss_q, loss_d;
    logic [1:0]  retry_q, retry_d;
    logic        load_q, load_d, sel_q, sel_d, locked_q, locked_d, fault_q, fault_d;
    logic [4:0]  lg_q, lg_d;
    logic        err_out;
    logic        unused_sign;

    // bit0 is only consumed by the external loopback mux
    assign unused_sign = pll_error_i[0];
    assign err_out     = pll_error_i[1];

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        ld_d    = '0;
        acq_d   = '0;
        win_d   = '0;
        loss_d  = '0;
        retry_d = retry_q;
        case (state_q)
            IDLE: state_d = swipt_alive_i ? LOAD : IDLE;
            LOAD: begin
                if (!swipt_alive_i) state_d = IDLE;
                else if (ld_q == LD_LAST) state_d = ACQUIRE;
                else ld_d = ld_q + 8'd1;
            end
            ACQUIRE: begin
                if (!swipt_alive_i) state_d = IDLE;
                else begin
                    win_d = err_out ? 9'd0 : (win_q == 9'h1FF ? win_q : win_q + 9'd1);
                    acq_d = acq_q == 16'hFFFF ? acq_q : acq_q + 16'd1;
                    // lock is tested first so it wins over a coincident timeout
                    if (win_d == LOCK_C) begin
                        state_d = TRACK;
                        win_d   = '0;
                        acq_d   = '0;
                    end else if (acq_d == TMO_C) begin
                        retry_d = retry_q == 2'd3 ? retry_q : retry_q + 2'd1;
                        state_d = (32'(retry_q) + 32'd1 < MAX_RETRY) ? LOAD : FAULT;
                        win_d   = '0;
                        acq_d   = '0;
                    end
                end
            end
            TRACK: begin
                if (!swipt_alive_i) state_d = IDLE;
                else begin
                    loss_d = err_out ? (loss_q == 5'h1F ? loss_q : loss_q + 5'd1) : 5'd0;
                    if (loss_d == LOSS_C) begin
                        state_d = ACQUIRE;
                        loss_d  = '0;
                    end
                end
            end
            FAULT: state_d = fault_clr_i ? IDLE : FAULT;
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) retry_d = '0;
        if (cfg_wr_i && (state_q == IDLE || state_q == FAULT)) freq_d = cfg_freq_i;
        load_d   = state_d inside {IDLE, LOAD, FAULT};
        sel_d    = state_d inside {ACQUIRE, TRACK};
        lg_d     = state_d == TRACK ? LG_TRK : LG_ACQ;
        locked_d = state_d == TRACK;
        fault_d  = state_d == FAULT;
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q  <= IDLE;
            freq_q   <= F_DEFAULT;
            ld_q     <= '0;
            acq_q    <= '0;
            win_q    <= '0;
            loss_q   <= '0;
            retry_q  <= '0;
            load_q   <= 1'b1;
            sel_q    <= 1'b0;
            lg_q     <= LG_ACQ;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            ld_q     <= ld_d;
            acq_q    <= acq_d;
            win_q    <= win_d;
            loss_q   <= loss_d;
            retry_q  <= retry_d;
            load_q   <= load_d;
            sel_q    <= sel_d;
            lg_q     <= lg_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
        end
    end

    assign load_freq_o  = load_q;
    assign freq_out_o   = freq_q;
    assign lgcoef_o     = lg_q;
    assign pll_in_sel_o = sel_q;
    assign locked_o     = locked_q;
    assign fault_o      = fault_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: directed bench for pll_lock_ctrl; inputs change and outputs are checked on the falling edge.
// ACQ_TIMEOUT is shortened so the three-timeout fault path stays short.
module tb_pll_lock_ctrl;
    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        swipt_alive = 1'b0;
    logic [1:0]  pll_error = 2'b00;
    logic        cfg_wr = 1'b0;
    logic [31:0] cfg_freq = '0;
    logic        fault_clr = 1'b0;
    logic        load_freq, pll_in_sel, locked, fault;
    logic [31:0] freq_out;
    logic [4:0]  lgcoef;
    logic [2:0]  state;
    int          checks = 0;
    int          errors = 0;

    pll_lock_ctrl #(.ACQ_TIMEOUT(1000)) dut (
        .clk(clk), .nrst(nrst), .swipt_alive_i(swipt_alive), .pll_error_i(pll_error),
        .cfg_wr_i(cfg_wr), .cfg_freq_i(cfg_freq), .fault_clr_i(fault_clr),
        .load_freq_o(load_freq), .freq_out_o(freq_out), .lgcoef_o(lgcoef),
        .pll_in_sel_o(pll_in_sel), .locked_o(locked), .fault_o(fault), .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        nrst = 1'b1;
        cyc(2);
        nrst = 1'b0;
        checks++;
        if ({state, load_freq, freq_out, lgcoef, pll_in_sel, locked, fault} !== {3'd0, 1'b1, 32'h9C40, 5'd8, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: st=%0d ld=%b f=%h lg=%0d sel=%b lk=%b flt=%b", state, load_freq, freq_out, lgcoef, pll_in_sel, locked, fault);
        end
    endtask

    task automatic test_cfg_idle;
        cfg_wr = 1'b1;
        cfg_freq = 32'h1388;
        cyc(1);
        cfg_wr = 1'b0;
        checks++;
        if (freq_out !== 32'h1388) begin errors++; $display("FAIL cfg_idle: got %h want 00001388", freq_out); end
    endtask

    task automatic test_lock;
        swipt_alive = 1'b1;
        pll_error = 2'b00;
        cyc(1);
        checks++;
        if (state !== 3'd1 || load_freq !== 1'b1) begin errors++; $display("FAIL load_entry: st=%0d ld=%b want 1 1", state, load_freq); end
        cyc(3);
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL load_4th: st=%0d want 1", state); end
        cyc(1);
        checks++;
        if ({state, load_freq, pll_in_sel, lgcoef} !== {3'd2, 1'b0, 1'b1, 5'd8}) begin
            errors++;
            $display("FAIL acq_entry: st=%0d ld=%b sel=%b lg=%0d want 2 0 1 8", state, load_freq, pll_in_sel, lgcoef);
        end
        cyc(255);
        checks++;
        if (state !== 3'd2 || locked !== 1'b0) begin errors++; $display("FAIL prelock: st=%0d lk=%b want 2 0", state, locked); end
        cyc(1);
        checks++;
        if ({state, locked, lgcoef} !== {3'd3, 1'b1, 5'd16}) begin
            errors++;
            $display("FAIL lock: st=%0d lk=%b lg=%0d want 3 1 16", state, locked, lgcoef);
        end
    endtask

    task automatic test_cfg_track;
        cfg_wr = 1'b1;
        cfg_freq = 32'hDEAD0000;
        cyc(1);
        cfg_wr = 1'b0;
        checks++;
        if (freq_out !== 32'h1388) begin errors++; $display("FAIL cfg_track: got %h want 00001388", freq_out); end
    endtask

    task automatic test_loss;
        pll_error = 2'b10;
        cyc(15);
        pll_error = 2'b00;
        checks++;
        if (state !== 3'd3 || locked !== 1'b1) begin errors++; $display("FAIL loss15: st=%0d lk=%b want 3 1", state, locked); end
        cyc(1);
        pll_error = 2'b11;
        cyc(16);
        pll_error = 2'b00;
        checks++;
        if ({state, locked, lgcoef, pll_in_sel} !== {3'd2, 1'b0, 5'd8, 1'b1}) begin
            errors++;
            $display("FAIL loss16: st=%0d lk=%b lg=%0d sel=%b want 2 0 8 1", state, locked, lgcoef, pll_in_sel);
        end
    endtask

    task automatic test_glitch;
        cyc(200);
        pll_error = 2'b10;
        cyc(1);
        pll_error = 2'b00;
        cyc(255);
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL glitch_hold: st=%0d want 2", state); end
        cyc(1);
        checks++;
        if (state !== 3'd3 || locked !== 1'b1) begin errors++; $display("FAIL glitch_lock: st=%0d lk=%b want 3 1", state, locked); end
    endtask

    task automatic test_swipt_drop;
        swipt_alive = 1'b0;
        cyc(1);
        checks++;
        if ({state, load_freq, locked, pll_in_sel, freq_out} !== {3'd0, 1'b1, 1'b0, 1'b0, 32'h1388}) begin
            errors++;
            $display("FAIL swipt_drop: st=%0d ld=%b lk=%b sel=%b f=%h", state, load_freq, locked, pll_in_sel, freq_out);
        end
    endtask

    task automatic test_reset_acq;
        swipt_alive = 1'b1;
        cyc(5);
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL pre_rst_acq: st=%0d want 2", state); end
        nrst = 1'b1;
        swipt_alive = 1'b0;
        cfg_wr = 1'b1;
        cfg_freq = 32'hDEAD0000;
        fault_clr = 1'b1;
        cyc(1);
        nrst = 1'b0;
        cfg_wr = 1'b0;
        fault_clr = 1'b0;
        checks++;
        if ({state, load_freq, freq_out, lgcoef, pll_in_sel, locked, fault} !== {3'd0, 1'b1, 32'h9C40, 5'd8, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_acq: st=%0d ld=%b f=%h lg=%0d sel=%b lk=%b flt=%b", state, load_freq, freq_out, lgcoef, pll_in_sel, locked, fault);
        end
    endtask

    task automatic test_timeout;
        pll_error = 2'b10;
        swipt_alive = 1'b1;
        cyc(5);
        for (int k = 0; k < 3; k++) begin
            cyc(999);
            checks++;
            if (state !== 3'd2) begin errors++; $display("FAIL tmo_hold%0d: st=%0d want 2", k, state); end
            cyc(1);
            checks++;
            if (state !== (k < 2 ? 3'd1 : 3'd4)) begin errors++; $display("FAIL tmo_next%0d: st=%0d want %0d", k, state, k < 2 ? 1 : 4); end
            if (k < 2) cyc(4);
        end
        checks++;
        if ({fault, load_freq, pll_in_sel, locked} !== 4'b1100) begin
            errors++;
            $display("FAIL fault_out: flt=%b ld=%b sel=%b lk=%b want 1 1 0 0", fault, load_freq, pll_in_sel, locked);
        end
        swipt_alive = 1'b0;
        cfg_wr = 1'b1;
        cfg_freq = 32'hABCD;
        cyc(1);
        cfg_wr = 1'b0;
        cyc(1);
        checks++;
        if (state !== 3'd4 || freq_out !== 32'hABCD) begin errors++; $display("FAIL fault_stay: st=%0d f=%h want 4 0000abcd", state, freq_out); end
        pll_error = 2'b00;
        fault_clr = 1'b1;
        cyc(1);
        fault_clr = 1'b0;
        checks++;
        if (state !== 3'd0 || fault !== 1'b0) begin errors++; $display("FAIL fault_clr: st=%0d flt=%b want 0 0", state, fault); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_cfg_idle;
        test_lock;
        test_cfg_track;
        test_loss;
        test_glitch;
        test_swipt_drop;
        test_reset_acq;
        test_timeout;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
